frontend_cmd_decoder: RTL and testbench
=======================================

# frontend_cmd_decoder

Receiving end of the frontend interconnection request path for one DRAM bank. It accepts tagged `frontend_interconnection_request_t` requests over a valid/ready handshake and tracks the bank's open row. It expands each request into the minimal `bank_command_t` sequence: PRECHARGE/ACTIVE as needed, then READ/WRITE or READ/WRITE with auto-precharge. It also services refresh requests between frontend requests. It sits between the core interconnect arbiter and the bank timing/IO FSM, which enforces tRCD/tRP/tRFC.

## Interface
Parameters:
- `BANK_ID`, default 3'd0: value driven on `cmd.bank_addr`.
- `BURST`, default `BL_8`: value driven on `cmd.burst_length`.
- `CLOSED_PAGE`, default 0: when 1, issue `CMD_RDA`/`CMD_WRA` and leave the bank closed after every access.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready` at a rising edge.
- `in_req` in `frontend_interconnection_request_t` (1+1+`ROW_BITS`+`COL_BITS`+5+2): tagged request.
- `cmd_valid` out 1: `cmd` valid.
- `cmd_ready` in 1: downstream accepts `cmd`.
- `cmd` out `bank_command_t` (36): command to the bank FSM.
- `cmd_req_id` out 5: tag, valid only with a READ/WRITE/RDA/WRA command.
- `cmd_core_num` out 2: tag, valid only with a READ/WRITE/RDA/WRA command.
- `cmd_data_type` out 1: `request_data_type_t`, valid only with a READ/WRITE/RDA/WRA command.
- `ref_req` in 1: level request for refresh, held until `ref_done`.
- `ref_done` out 1: one-cycle pulse when `CMD_REFRESH` is handshaken.
- `row_open` out 1: bank currently has an open row.
- `open_row` out 14: row address of the open row.

## Operation
- States: IDLE, PRE, ACT, RW, REF_PRE, REF.
- `in_ready` is combinational: `(state==IDLE) && !ref_req`. Refresh has priority over new requests.
- **IDLE**
  - If `ref_req` and `row_open`: go to REF_PRE.
  - Else if `ref_req`: go to REF.
  - Else on an accepted request, latch it, then:
    - row closed: go to ACT;
    - row open and `row_addr != open_row`: go to PRE;
    - row open and rows equal (hit): go to RW.
- `cmd_valid` = 1 in every non-IDLE state. The state advances only on `cmd_valid && cmd_ready`.
- Command per state:
  - PRE and REF_PRE: `CMD_PRECHARGE`.
  - ACT: `CMD_ACTIVE`.
  - RW: `CMD_READ` or `CMD_WRITE` per op_type (`CMD_RDA`/`CMD_WRA` if `CLOSED_PAGE`).
  - REF: `CMD_REFRESH`.
- Transitions on handshake:
  - PRE→ACT, clears `row_open`.
  - ACT→RW, sets `row_open` and `open_row <= row_addr`.
  - RW→IDLE, clears `row_open` if `CLOSED_PAGE`.
  - REF_PRE→REF, clears `row_open`.
  - REF→IDLE, pulses `ref_done` in the following cycle.
- Address mapping:
  - `row_addr` and `col_addr` are zero-extended to 14 bits.
  - `col_addr` is driven as zero for PRE, ACT and REF.
  - `row_addr` is driven as zero for PRE and REF.
  - `bank_addr` = `BANK_ID`; `burst_length` = `BURST` on all commands.
- When `cmd_valid`=0: `cmd.cmd = CMD_NOP` and all other outputs are zero.
- A `ref_req` rising while a request is mid-sequence waits. The current request completes its RW first.
- Reset mid-operation: the latched request is discarded, state goes to IDLE, and `row_open` is cleared. The bank FSM is reset together with this block.

## Timing
- Reset values: state IDLE, `cmd_valid`=0, `cmd`=NOP/zeros, tags 0, `ref_done`=0, `row_open`=0, `open_row`=0.
- `in_ready`=1 after reset when `ref_req`=0.
- All outputs except `in_ready` are registered.
- Request accepted at edge T → first command has `cmd_valid`=1 from T+1.
- Latency with `cmd_ready` tied high (request accepted at edge T):
  - hit: RW at T+1, `in_ready` at T+2;
  - closed: ACT at T+1, RW at T+2, `in_ready` at T+3;
  - miss: PRE/ACT/RW at T+1..T+3, `in_ready` at T+4.
- `cmd` and the tags are held stable while `cmd_valid && !cmd_ready`.
- `ref_done` is asserted the cycle after the REF handshake. `ref_req` may drop that same cycle. If `ref_req` is still high in the next IDLE cycle, another refresh is started.
- Throughput: at most one request in flight; no back-to-back acceptance.

## Test plan
- Reset, closed bank, read request (row 0x12, col 0x34, id 5, core 2), `cmd_ready`=1 → ACT(row 0x12) at T+1, READ(col 0x34, `cmd_req_id`=5, `cmd_core_num`=2) at T+2; `row_open`=1, `open_row`=0x12.
- Write to row 0x12 after the read above → single WRITE at T+1; no PRE/ACT.
- Read to row 0x40 with row 0x12 open → PRE, ACT(0x40), READ in consecutive cycles; `open_row`=0x40.
- `ref_req`=1 with a row open and `in_valid`=1 → `in_ready`=0; PRE then REFRESH; `ref_done` pulse; `row_open`=0; the request is accepted afterwards.
- `cmd_ready` held low 4 cycles during ACT → `cmd` stable for 4 cycles, then RW the cycle after `cmd_ready` rises.
- `CLOSED_PAGE`=1: two reads to the same row → ACT, RDA, ACT, RDA; `row_open`=0 after each. Separately, `rst_n` pulsed low during PRE → outputs return to reset values immediately.

Source files
------------

// File: rtl/frontend_cmd_decoder.sv
// Per-bank frontend command decoder: turns tagged requests and refresh requests
// into the minimal PRECHARGE/ACTIVE/READ/WRITE/REFRESH sequence for the bank FSM.
package frontend_cmd_pkg;
   localparam int ROW_BITS = 14;
   localparam int COL_BITS = 10;

   typedef enum logic [2:0] {
      CMD_NOP       = 3'd0,
      CMD_PRECHARGE = 3'd1,
      CMD_ACTIVE    = 3'd2,
      CMD_READ      = 3'd3,
      CMD_WRITE     = 3'd4,
      CMD_RDA       = 3'd5,
      CMD_WRA       = 3'd6,
      CMD_REFRESH   = 3'd7
   } bank_cmd_e;

   typedef enum logic [1:0] {
      BL_4   = 2'd0,
      BL_8   = 2'd1,
      BL_16  = 2'd2,
      BL_OTF = 2'd3
   } burst_len_e;

   typedef enum logic {
      OP_READ  = 1'b0,
      OP_WRITE = 1'b1
   } request_op_type_t;

   typedef enum logic {
      DATA_INSTR   = 1'b0,
      DATA_OPERAND = 1'b1
   } request_data_type_t;

   typedef struct packed {
      request_op_type_t    op_type;
      request_data_type_t  data_type;
      logic [ROW_BITS-1:0] row_addr;
      logic [COL_BITS-1:0] col_addr;
      logic [4:0]          req_id;
      logic [1:0]          core_num;
   } frontend_interconnection_request_t;

   typedef struct packed {
      bank_cmd_e   cmd;
      logic [2:0]  bank_addr;
      logic [13:0] row_addr;
      logic [13:0] col_addr;
      burst_len_e  burst_length;
   } bank_command_t;
endpackage

module frontend_cmd_decoder
   import frontend_cmd_pkg::*;
#(
   parameter logic [2:0] BANK_ID     = 3'd0,
   parameter burst_len_e BURST       = BL_8,
   parameter bit         CLOSED_PAGE = 1'b0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  frontend_interconnection_request_t in_req,
   output logic                              cmd_valid,
   input  logic                              cmd_ready,
   output bank_command_t                     cmd,
   output logic [4:0]                        cmd_req_id,
   output logic [1:0]                        cmd_core_num,
   output request_data_type_t                cmd_data_type,
   input  logic                              ref_req,
   output logic                              ref_done,
   output logic                              row_open,
   output logic [13:0]                       open_row
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRE     = 3'd1,
      ST_ACT     = 3'd2,
      ST_RW      = 3'd3,
      ST_REF_PRE = 3'd4,
      ST_REF     = 3'd5
   } state_e;

   state_e                            r_state, w_state_nxt;
   frontend_interconnection_request_t r_req, w_req_nxt;
   logic                              r_row_open, w_row_open_nxt;
   logic [13:0]                       r_open_row, w_open_row_nxt;
   logic                              r_cmd_valid, w_cmd_valid_nxt;
   bank_command_t                     r_cmd, w_cmd_nxt;
   logic [4:0]                        r_req_id, w_req_id_nxt;
   logic [1:0]                        r_core_num, w_core_num_nxt;
   request_data_type_t                r_data_type, w_data_type_nxt;
   logic                              r_ref_done;
   logic                              w_hs;

   assign w_hs     = r_cmd_valid && cmd_ready;
   assign in_ready = (r_state == ST_IDLE) && !ref_req;

   // Sequencing: refresh wins in IDLE; every other state advances only on a handshake.
   always_comb begin
      w_state_nxt    = r_state;
      w_req_nxt      = r_req;
      w_row_open_nxt = r_row_open;
      w_open_row_nxt = r_open_row;
      case (r_state)
         ST_IDLE: begin
            if (ref_req && r_row_open) begin
               w_state_nxt = ST_REF_PRE;
            end else if (ref_req) begin
               w_state_nxt = ST_REF;
            end else if (in_valid) begin
               w_req_nxt = in_req;
               if (!r_row_open) begin
                  w_state_nxt = ST_ACT;
               end else if (in_req.row_addr != r_open_row) begin
                  w_state_nxt = ST_PRE;
               end else begin
                  w_state_nxt = ST_RW;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_PRE: begin
            if (w_hs) begin
               w_state_nxt    = ST_ACT;
               w_row_open_nxt = 1'b0;
            end else begin
               w_state_nxt = ST_PRE;
            end
         end
         ST_ACT: begin
            if (w_hs) begin
               w_state_nxt    = ST_RW;
               w_row_open_nxt = 1'b1;
               w_open_row_nxt = r_req.row_addr;
            end else begin
               w_state_nxt = ST_ACT;
            end
         end
         ST_RW: begin
            if (w_hs) begin
               w_state_nxt = ST_IDLE;
               if (CLOSED_PAGE) begin
                  w_row_open_nxt = 1'b0;
               end else begin
                  w_row_open_nxt = r_row_open;
               end
            end else begin
               w_state_nxt = ST_RW;
            end
         end
         ST_REF_PRE: begin
            if (w_hs) begin
               w_state_nxt    = ST_REF;
               w_row_open_nxt = 1'b0;
            end else begin
               w_state_nxt = ST_REF_PRE;
            end
         end
         ST_REF: begin
            if (w_hs) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_REF;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Outputs are built from the next state so they can be registered without a cycle of lag.
   always_comb begin
      w_cmd_valid_nxt = 1'b0;
      w_cmd_nxt       = '0;
      w_req_id_nxt    = 5'd0;
      w_core_num_nxt  = 2'd0;
      w_data_type_nxt = DATA_INSTR;
      case (w_state_nxt)
         ST_PRE, ST_REF_PRE: begin
            w_cmd_valid_nxt = 1'b1;
            w_cmd_nxt.cmd   = CMD_PRECHARGE;
         end
         ST_ACT: begin
            w_cmd_valid_nxt    = 1'b1;
            w_cmd_nxt.cmd      = CMD_ACTIVE;
            w_cmd_nxt.row_addr = 14'(w_req_nxt.row_addr);
         end
         ST_RW: begin
            w_cmd_valid_nxt = 1'b1;
            if (w_req_nxt.op_type == OP_WRITE) begin
               w_cmd_nxt.cmd = CLOSED_PAGE ? CMD_WRA : CMD_WRITE;
            end else begin
               w_cmd_nxt.cmd = CLOSED_PAGE ? CMD_RDA : CMD_READ;
            end
            w_cmd_nxt.row_addr = 14'(w_req_nxt.row_addr);
            w_cmd_nxt.col_addr = 14'(w_req_nxt.col_addr);
            w_req_id_nxt       = w_req_nxt.req_id;
            w_core_num_nxt     = w_req_nxt.core_num;
            w_data_type_nxt    = w_req_nxt.data_type;
         end
         ST_REF: begin
            w_cmd_valid_nxt = 1'b1;
            w_cmd_nxt.cmd   = CMD_REFRESH;
         end
         default: begin
            w_cmd_valid_nxt = 1'b0;
         end
      endcase
      if (w_cmd_valid_nxt) begin
         w_cmd_nxt.bank_addr    = BANK_ID;
         w_cmd_nxt.burst_length = BURST;
      end else begin
         w_cmd_nxt.bank_addr    = 3'd0;
         w_cmd_nxt.burst_length = BL_4;
      end
   end

   // State, latched request and open-row tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_req      <= '0;
         r_row_open <= 1'b0;
         r_open_row <= 14'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_req      <= w_req_nxt;
         r_row_open <= w_row_open_nxt;
         r_open_row <= w_open_row_nxt;
      end
   end

   // Registered command, tags and refresh acknowledge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_valid <= 1'b0;
         r_cmd       <= '0;
         r_req_id    <= 5'd0;
         r_core_num  <= 2'd0;
         r_data_type <= DATA_INSTR;
         r_ref_done  <= 1'b0;
      end else begin
         r_cmd_valid <= w_cmd_valid_nxt;
         r_cmd       <= w_cmd_nxt;
         r_req_id    <= w_req_id_nxt;
         r_core_num  <= w_core_num_nxt;
         r_data_type <= w_data_type_nxt;
         r_ref_done  <= (r_state == ST_REF) && w_hs;
      end
   end

   assign cmd_valid     = r_cmd_valid;
   assign cmd           = r_cmd;
   assign cmd_req_id    = r_req_id;
   assign cmd_core_num  = r_core_num;
   assign cmd_data_type = r_data_type;
   assign ref_done      = r_ref_done;
   assign row_open      = r_row_open;
   assign open_row      = r_open_row;

endmodule

// File: tb/tb_frontend_cmd_decoder.sv
// Scoreboard bench for frontend_cmd_decoder: one open-page and one closed-page instance,
// expected command streams derived from a row-buffer model of the bank.
module tb_frontend_cmd_decoder;
   import frontend_cmd_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   logic                              in_valid [2];
   logic                              in_ready [2];
   frontend_interconnection_request_t in_req [2];
   logic                              cmd_valid [2];
   logic                              cmd_ready [2];
   bank_command_t                     cmd [2];
   logic [4:0]                        req_id [2];
   logic [1:0]                        core_num [2];
   request_data_type_t                data_type [2];
   logic                              ref_req [2];
   logic                              ref_done [2];
   logic                              row_open [2];
   logic [13:0]                       open_row [2];

   frontend_cmd_decoder #(.BANK_ID(3'd5), .BURST(BL_4), .CLOSED_PAGE(1'b0)) u_dut_open (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_req(in_req[0]),
      .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd(cmd[0]), .cmd_req_id(req_id[0]),
      .cmd_core_num(core_num[0]), .cmd_data_type(data_type[0]), .ref_req(ref_req[0]),
      .ref_done(ref_done[0]), .row_open(row_open[0]), .open_row(open_row[0]));

   frontend_cmd_decoder #(.BANK_ID(3'd2), .BURST(BL_8), .CLOSED_PAGE(1'b1)) u_dut_closed (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_req(in_req[1]),
      .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd(cmd[1]), .cmd_req_id(req_id[1]),
      .cmd_core_num(core_num[1]), .cmd_data_type(data_type[1]), .ref_req(ref_req[1]),
      .ref_done(ref_done[1]), .row_open(row_open[1]), .open_row(open_row[1]));

   always #5 clk = ~clk;

   typedef struct {
      bank_cmd_e   op;
      logic [13:0] row;
      logic [13:0] col;
      logic [4:0]  id;
      logic [1:0]  core;
      logic        dt;
      int          cyc;
   } exp_t;

   exp_t        q0[$];
   exp_t        q1[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          refdone_at [2];
   bit          m_open [2];
   logic [13:0] m_row [2];
   bit          prev_hold [2];
   logic [43:0] prev_word [2];
   bit          rnd_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      if (rnd_en) cmd_ready[0] = ($urandom_range(0, 3) != 0);
   end

   function automatic logic [2:0] bank_of(input int d);
      return (d == 0) ? 3'd5 : 3'd2;
   endfunction

   function automatic burst_len_e burst_of(input int d);
      return (d == 0) ? BL_4 : BL_8;
   endfunction

   function automatic bit closed_of(input int d);
      return (d == 1);
   endfunction

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t mk(input bank_cmd_e op, input logic [13:0] row, input logic [13:0] col,
                               input logic [4:0] id, input logic [1:0] core, input logic dt, input int c);
      exp_t e;
      e.op = op; e.row = row; e.col = col; e.id = id; e.core = core; e.dt = dt; e.cyc = c;
      return e;
   endfunction

   function automatic frontend_interconnection_request_t mkreq(input bit wr, input logic [13:0] row,
         input logic [9:0] col, input logic [4:0] id, input logic [1:0] core, input bit dt);
      frontend_interconnection_request_t r;
      r.op_type   = wr ? OP_WRITE : OP_READ;
      r.data_type = dt ? DATA_OPERAND : DATA_INSTR;
      r.row_addr  = row;
      r.col_addr  = col;
      r.req_id    = id;
      r.core_num  = core;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   // Row-buffer model: a different open row costs a precharge, any closed bank costs an activate.
   task automatic model_req(input int d, input frontend_interconnection_request_t r, input int t0);
      int        k = 0;
      bit        miss;
      bank_cmd_e op;
      miss = m_open[d] && (m_row[d] != r.row_addr);
      if (miss) begin
         push(d, mk(CMD_PRECHARGE, 14'd0, 14'd0, 5'd0, 2'd0, 1'b0, (t0 < 0) ? -1 : t0 + k));
         k++;
      end
      if (miss || !m_open[d]) begin
         push(d, mk(CMD_ACTIVE, r.row_addr, 14'd0, 5'd0, 2'd0, 1'b0, (t0 < 0) ? -1 : t0 + k));
         k++;
      end
      if (r.op_type == OP_WRITE) op = closed_of(d) ? CMD_WRA : CMD_WRITE;
      else op = closed_of(d) ? CMD_RDA : CMD_READ;
      push(d, mk(op, r.row_addr, {4'd0, r.col_addr}, r.req_id, r.core_num, r.data_type,
                 (t0 < 0) ? -1 : t0 + k));
      m_open[d] = !closed_of(d);
      m_row[d]  = r.row_addr;
   endtask

   task automatic model_ref(input int d, input int t0);
      int k = 0;
      if (m_open[d]) begin
         push(d, mk(CMD_PRECHARGE, 14'd0, 14'd0, 5'd0, 2'd0, 1'b0, (t0 < 0) ? -1 : t0));
         k++;
      end
      push(d, mk(CMD_REFRESH, 14'd0, 14'd0, 5'd0, 2'd0, 1'b0, (t0 < 0) ? -1 : t0 + k));
      m_open[d] = 1'b0;
   endtask

   task automatic mon_step(input int d);
      exp_t        e;
      logic [43:0] word;
      word = {cmd[d], req_id[d], core_num[d], data_type[d]};
      if (cmd_valid[d]) begin
         if (prev_hold[d]) chk($sformatf("hold_stable%0d", d), 64'(word), 64'(prev_word[d]));
         if (cmd_ready[d]) begin
            prev_hold[d] = 1'b0;
            if (qsize(d) == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_cmd%0d: got cmd 0x%0h, expected no command", d, cmd[d]);
            end else begin
               if (d == 0) e = q0.pop_front();
               else e = q1.pop_front();
               chk($sformatf("cmd%0d", d), 64'(word),
                   64'({e.op, bank_of(d), e.row, e.col, burst_of(d), e.id, e.core, e.dt}));
               if (e.cyc >= 0) chk($sformatf("cmd_cycle%0d", d), 64'(cyc), 64'(e.cyc));
               if (e.op == CMD_REFRESH) refdone_at[d] = cyc + 1;
            end
         end else begin
            prev_hold[d] = 1'b1;
            prev_word[d] = word;
         end
      end else begin
         prev_hold[d] = 1'b0;
         chk($sformatf("idle_outputs%0d", d), 64'(word), 64'd0);
      end
      chk($sformatf("ref_done%0d", d), 64'(ref_done[d]), 64'(cyc == refdone_at[d]));
   endtask

   always @(negedge clk) mon_step(0);
   always @(negedge clk) mon_step(1);

   task automatic wait_done(input int d);
      int n = 0;
      while (qsize(d) != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("sequence_timeout", 64'(qsize(d)), 64'd0);
      @(negedge clk);
      #1;
      chk("in_ready_idle", 64'(in_ready[d]), 64'd1);
      chk("row_open", 64'(row_open[d]), 64'(m_open[d]));
      if (m_open[d]) chk("open_row", 64'(open_row[d]), 64'(m_row[d]));
   endtask

   // hold > 0: stall cmd_ready for that many cycles on the first command; hold < 0: return after accept.
   task automatic do_req(input int d, input frontend_interconnection_request_t r, input bit timed,
                         input int hold);
      bit acc = 1'b0;
      if (hold > 0) cmd_ready[d] = 1'b0;
      in_req[d]   = r;
      in_valid[d] = 1'b1;
      #1;
      for (int n = 0; n < 200 && !acc; n++) begin
         if (in_ready[d]) begin
            model_req(d, r, timed ? cyc + 1 : -1);
            @(posedge clk);
            #1;
            in_valid[d] = 1'b0;
            acc = 1'b1;
         end else begin
            @(negedge clk);
            #1;
         end
      end
      if (!acc) begin
         chk("accept_timeout", 64'(in_ready[d]), 64'd1);
         in_valid[d] = 1'b0;
      end
      if (hold > 0) begin
         repeat (hold) begin
            @(negedge clk);
            chk("held_act", 64'({cmd_valid[d], cmd[d].cmd}), 64'({1'b1, CMD_ACTIVE}));
         end
         @(posedge clk);
         #1;
         cmd_ready[d] = 1'b1;
         @(negedge clk);
         @(negedge clk);
         chk("rw_after_release", 64'(cmd[d].cmd), 64'(CMD_READ));
      end
      if (hold >= 0) wait_done(d);
   endtask

   task automatic do_ref(input int d, input bit timed);
      bit seen = 1'b0;
      ref_req[d] = 1'b1;
      model_ref(d, timed ? cyc + 1 : -1);
      for (int n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         seen = ref_done[d];
      end
      if (!seen) chk("ref_done_timeout", 64'd0, 64'd1);
      ref_req[d] = 1'b0;
      #1;
      chk("ref_in_ready", 64'(in_ready[d]), 64'd1);
      chk("ref_row_closed", 64'(row_open[d]), 64'd0);
      chk("ref_drained", 64'(qsize(d)), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      frontend_interconnection_request_t r;
      logic [13:0] pool [4];
      int d;
      pool[0] = 14'h0012; pool[1] = 14'h0040; pool[2] = 14'h3fff; pool[3] = 14'h0000;
      for (int i = 0; i < 2; i++) begin
         in_valid[i] = 1'b0; in_req[i] = '0; cmd_ready[i] = 1'b1; ref_req[i] = 1'b0;
         refdone_at[i] = -1; m_open[i] = 1'b0; m_row[i] = 14'd0; prev_hold[i] = 1'b0;
         prev_word[i] = 44'd0;
      end
      #2 rst_n = 1'b0;
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_cmd_valid", 64'(cmd_valid[i]), 64'd0);
         chk("rst_cmd", 64'({cmd[i], req_id[i], core_num[i], data_type[i]}), 64'd0);
         chk("rst_row", 64'({row_open[i], open_row[i], ref_done[i]}), 64'd0);
         chk("rst_in_ready", 64'(in_ready[i]), 64'd1);
      end
      rst_n = 1'b1;

      do_req(0, mkreq(1'b0, 14'h12, 10'h34, 5'd5, 2'd2, 1'b1), 1'b1, 0);
      do_req(0, mkreq(1'b1, 14'h12, 10'h3ff, 5'd9, 2'd1, 1'b0), 1'b1, 0);
      do_req(0, mkreq(1'b0, 14'h40, 10'h001, 5'd31, 2'd3, 1'b1), 1'b1, 0);

      r = mkreq(1'b1, 14'h40, 10'h155, 5'd17, 2'd0, 1'b1);
      in_req[0] = r; in_valid[0] = 1'b1; ref_req[0] = 1'b1;
      #1;
      chk("ref_blocks_in_ready", 64'(in_ready[0]), 64'd0);
      do_ref(0, 1'b1);
      do_req(0, r, 1'b1, 0);

      do_ref(0, 1'b1);
      do_req(0, mkreq(1'b0, 14'h05, 10'h0aa, 5'd3, 2'd1, 1'b0), 1'b0, 4);

      do_req(1, mkreq(1'b0, 14'h21, 10'h010, 5'd7, 2'd3, 1'b0), 1'b1, 0);
      do_req(1, mkreq(1'b0, 14'h21, 10'h020, 5'd8, 2'd2, 1'b1), 1'b1, 0);

      rnd_en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         d = $urandom_range(0, 1);
         if ($urandom_range(0, 5) == 0) begin
            do_ref(d, d == 1);
         end else begin
            r = mkreq(1'($urandom), pool[$urandom_range(0, 3)], 10'($urandom), 5'($urandom),
                      2'($urandom), 1'($urandom));
            do_req(d, r, d == 1, 0);
         end
      end
      rnd_en = 1'b0;
      @(posedge clk);
      #2 cmd_ready[0] = 1'b1;
      @(negedge clk);
      #1;

      do_req(0, mkreq(1'b0, 14'h10, 10'h011, 5'd1, 2'd1, 1'b0), 1'b1, 0);
      cmd_ready[0] = 1'b0;
      do_req(0, mkreq(1'b1, 14'h20, 10'h022, 5'd2, 2'd2, 1'b1), 1'b0, -1);
      @(negedge clk);
      chk("pre_before_reset", 64'({cmd_valid[0], cmd[0].cmd}), 64'({1'b1, CMD_PRECHARGE}));
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_cmd", 64'({cmd_valid[0], cmd[0], req_id[0], core_num[0], data_type[0]}), 64'd0);
      chk("mid_rst_row", 64'({row_open[0], open_row[0], ref_done[0]}), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
      q0.delete();
      q1.delete();
      for (int i = 0; i < 2; i++) begin
         m_open[i] = 1'b0;
         m_row[i]  = 14'd0;
      end
      @(negedge clk);
      #1;
      rst_n        = 1'b1;
      cmd_ready[0] = 1'b1;
      do_req(0, mkreq(1'b0, 14'h33, 10'h044, 5'd4, 2'd3, 1'b0), 1'b1, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(qsize(0) + qsize(1)), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
